// File: rtl/pwm_ramp_ctrl_if.sv
// rtl/pwm_ramp_ctrl_if.sv - ramp command handshake between host logic and pwm_ramp_ctrl
interface pwm_ramp_ctrl_if #(
  parameter int N = 4,
  parameter int D = 16
);
  logic         cmd_valid;
  logic         cmd_ready;
  logic [N-1:0] cmd_target;
  logic [D-1:0] cmd_interval;
  logic         abort;

  // Host side issues commands and aborts
  modport master (
    output cmd_valid,
    output cmd_target,
    output cmd_interval,
    output abort,
    input  cmd_ready
  );

  // Controller side accepts commands
  modport slave (
    input  cmd_valid,
    input  cmd_target,
    input  cmd_interval,
    input  abort,
    output cmd_ready
  );
endinterface

// File: rtl/pwm_ramp_ctrl.sv
// rtl/pwm_ramp_ctrl.sv - steps a PWM duty value toward a commanded target at period boundaries
module pwm_ramp_ctrl #(
  parameter int N = 4,
  parameter int D = 16
) (
  input  logic          clk,
  input  logic          reset,
  pwm_ramp_ctrl_if.slave cmd,
  output logic [N-1:0]  w,
  output logic          period_start,
  output logic          busy,
  output logic          done
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RAMP = 1'b1
  } state_t;

  localparam logic [N-1:0] CNT_LAST = '1;
  localparam logic [N-1:0] W_ONE    = {{(N-1){1'b0}}, 1'b1};
  localparam logic [D-1:0] IVL_ONE  = {{(D-1){1'b0}}, 1'b1};

  state_t       state;
  logic [N-1:0] period_cnt;
  logic [N-1:0] tgt;
  logic [D-1:0] ivl;
  logic [D-1:0] ivl_cnt;
  logic         ready_q;
  logic [N-1:0] w_next;
  logic [D-1:0] ivl_in;

  assign cmd.cmd_ready = ready_q;

  // Boundary is the last cycle of the period, matching the PWM channel's counter
  assign period_start = (period_cnt == CNT_LAST);

  // Candidate stepped duty: one unit toward the target, never past it
  always_comb begin
    w_next = w;
    if (w < tgt) begin
      w_next = w + W_ONE;
    end else if (w > tgt) begin
      w_next = w - W_ONE;
    end
  end

  // An interval of zero would never step, so it is clamped to one period
  assign ivl_in = (cmd.cmd_interval == '0) ? IVL_ONE : cmd.cmd_interval;

  // Free-running period counter kept in phase with the PWM counter
  always_ff @(posedge clk) begin
    if (reset) begin
      period_cnt <= '0;
    end else begin
      period_cnt <= period_cnt + W_ONE;
    end
  end

  // Ramp sequencer: command acceptance, interval counting, duty stepping and abort
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      w       <= '0;
      tgt     <= '0;
      ivl     <= IVL_ONE;
      ivl_cnt <= '0;
      ready_q <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          ready_q <= 1'b1;
          busy    <= 1'b0;
          if (cmd.cmd_valid) begin
            tgt     <= cmd.cmd_target;
            ivl     <= ivl_in;
            ivl_cnt <= '0;
            if (cmd.cmd_target == w) begin
              done <= 1'b1;
            end else begin
              state   <= RAMP;
              ready_q <= 1'b0;
              busy    <= 1'b1;
            end
          end
        end
        RAMP: begin
          if (cmd.abort) begin
            // Abort wins even on a step edge; the duty freezes where it is
            state   <= IDLE;
            ready_q <= 1'b1;
            busy    <= 1'b0;
          end else if (period_start) begin
            if (ivl_cnt == ivl - IVL_ONE) begin
              ivl_cnt <= '0;
              w       <= w_next;
              if (w_next == tgt) begin
                done    <= 1'b1;
                state   <= IDLE;
                ready_q <= 1'b1;
                busy    <= 1'b0;
              end
            end else begin
              ivl_cnt <= ivl_cnt + IVL_ONE;
            end
          end
        end
        default: begin
          state   <= IDLE;
          ready_q <= 1'b1;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// tb/tb_pwm_ramp_ctrl.sv - directed self-checking bench for pwm_ramp_ctrl
module tb_pwm_ramp_ctrl;

  logic       clk;
  logic       reset;
  logic [3:0] w;
  logic       period_start;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;

  int   cyc;
  int   ndone;
  logic edge_ok;

  pwm_ramp_ctrl_if #(.N(4), .D(16)) bus ();

  pwm_ramp_ctrl #(.N(4), .D(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .cmd          (bus),
    .w            (w),
    .period_start (period_start),
    .busy         (busy),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; outputs are sampled 1ns after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Tick until w changes or the budget runs out; report cycles, done pulses seen, and
  // whether the change followed a boundary cycle
  task automatic wait_change(input int budget, output int cycles, output int dones, output logic at_edge);
    logic [3:0] w0;
    logic       ps_prev;
    w0      = w;
    cycles  = 0;
    dones   = 0;
    at_edge = 1'b0;
    ps_prev = 1'b0;
    while (w === w0 && cycles < budget) begin
      ps_prev = period_start;
      tick();
      cycles++;
      if (done === 1'b1) dones++;
    end
    at_edge = ps_prev;
  endtask

  task automatic send(input logic [3:0] t, input logic [15:0] i);
    bus.cmd_valid    = 1'b1;
    bus.cmd_target   = t;
    bus.cmd_interval = i;
    tick();
    bus.cmd_valid    = 1'b0;
  endtask

  initial begin
    reset            = 1'b1;
    bus.cmd_valid    = 1'b0;
    bus.cmd_target   = '0;
    bus.cmd_interval = '0;
    bus.abort        = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    // Reset state, period_cnt = 0
    chk("rst_w", w, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ready", bus.cmd_ready, 1);
    chk("rst_ps", period_start, 0);

    // Scenario 1: tgt=3 ivl=1 accepted at period_cnt=5
    repeat (5) tick();
    send(4'd3, 16'd1);
    chk("s1_busy", busy, 1);
    chk("s1_ready", bus.cmd_ready, 0);
    wait_change(40, cyc, ndone, edge_ok);
    chk("s1_w1", w, 1); chk("s1_c1", cyc, 10); chk("s1_e1", edge_ok, 1); chk("s1_d1", ndone, 0);
    wait_change(40, cyc, ndone, edge_ok);
    chk("s1_w2", w, 2); chk("s1_c2", cyc, 16); chk("s1_d2", ndone, 0);
    wait_change(40, cyc, ndone, edge_ok);
    chk("s1_w3", w, 3); chk("s1_c3", cyc, 16); chk("s1_d3", done, 1);
    chk("s1_busy_end", busy, 0);
    chk("s1_ready_end", bus.cmd_ready, 1);
    tick();
    chk("s1_done_pulse", done, 0);

    // Scenario 2: tgt=0 ivl=0 behaves as ivl=1
    send(4'd0, 16'd0);
    wait_change(40, cyc, ndone, edge_ok);
    chk("s2_w2", w, 2); chk("s2_c1", cyc, 14); chk("s2_e1", edge_ok, 1);
    wait_change(40, cyc, ndone, edge_ok);
    chk("s2_w1", w, 1); chk("s2_c2", cyc, 16);
    wait_change(40, cyc, ndone, edge_ok);
    chk("s2_w0", w, 0); chk("s2_c3", cyc, 16); chk("s2_done", ndone, 1);
    chk("s2_busy", busy, 0);
    tick();
    chk("s2_done_pulse", done, 0);

    // Scenario 3: 0 -> 10 stepping every third boundary
    send(4'd10, 16'd3);
    for (int k = 1; k <= 10; k++) begin
      wait_change(60, cyc, ndone, edge_ok);
      chk("s3_w", w, k);
      chk("s3_cyc", cyc, (k == 1) ? 46 : 48);
      chk("s3_edge", edge_ok, 1);
      chk("s3_done", ndone, (k == 10) ? 1 : 0);
    end
    chk("s3_busy", busy, 0);
    tick();

    // Scenario 4a: ramp down, abort mid-period at w=4
    send(4'd0, 16'd3);
    for (int k = 9; k >= 4; k--) begin
      wait_change(60, cyc, ndone, edge_ok);
      chk("s4_w", w, k);
      chk("s4_cyc", cyc, (k == 9) ? 46 : 48);
    end
    repeat (3) tick();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("s4_abort_busy", busy, 0);
    chk("s4_abort_ready", bus.cmd_ready, 1);
    chk("s4_abort_done", done, 0);
    wait_change(100, cyc, ndone, edge_ok);
    chk("s4_hold_w", w, 4);
    chk("s4_hold_done", ndone, 0);

    // Scenario 4b: abort on a boundary that would otherwise step
    send(4'd0, 16'd1);
    chk("s4b_busy", busy, 1);
    repeat (6) tick();
    chk("s4b_ps", period_start, 1);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("s4b_w", w, 4);
    chk("s4b_busy_end", busy, 0);
    chk("s4b_done", done, 0);
    tick();
    chk("s4b_w_hold", w, 4);

    // Scenario 4c: target equal to current duty completes immediately
    send(4'd4, 16'd5);
    chk("s4c_done", done, 1);
    chk("s4c_busy", busy, 0);
    chk("s4c_w", w, 4);
    tick();
    chk("s4c_done_pulse", done, 0);

    // Scenario 5: command during a ramp is ignored
    send(4'd6, 16'd1);
    bus.cmd_valid    = 1'b1;
    bus.cmd_target   = 4'd15;
    bus.cmd_interval = 16'd1;
    chk("s5_ready", bus.cmd_ready, 0);
    tick();
    bus.cmd_valid = 1'b0;
    wait_change(40, cyc, ndone, edge_ok);
    chk("s5_w5", w, 5); chk("s5_c1", cyc, 11);
    wait_change(40, cyc, ndone, edge_ok);
    chk("s5_w6", w, 6); chk("s5_done", ndone, 1);
    wait_change(40, cyc, ndone, edge_ok);
    chk("s5_hold", w, 6);

    // Scenario 6: reset mid-ramp at w=7
    send(4'd12, 16'd1);
    wait_change(40, cyc, ndone, edge_ok);
    chk("s6_w7", w, 7); chk("s6_c", cyc, 7);
    repeat (3) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("s6_w", w, 0);
    chk("s6_busy", busy, 0);
    chk("s6_done", done, 0);
    chk("s6_ready", bus.cmd_ready, 1);
    chk("s6_pcnt", dut.period_cnt, 0);
    wait_change(40, cyc, ndone, edge_ok);
    chk("s6_hold", w, 0);
    chk("s6_no_done", ndone, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
